regfile_mp: RTL

Parametrised multi-port register file, the successor to the 2R/1W 32x32 CPU register file. It provides NR synchronous read ports and NW write ports, with one-cycle read latency and full write-to-read bypass covering both the issue and the return cycle. Register 0 is hardwired to zero. A post-reset hardware clear FSM scrubs every entry, so contents are deterministic without software init. Sits in the decode/writeback stage of the superscalar pipeline.

---
 rtl/regfile_pkg.sv | 29 ++
 rtl/rf_read_port.sv | 87 ++++++++
 rtl/regfile_mp.sv | 138 +++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types, default sizes and parity helper for regfile_mp
// Contents: rf_state_e clear/ready state, default DW/AW/NR/NW, rf_parity().
// Optional feature macro: RF_PARITY_EN (sets RF_PAR_EN).
package regfile_pkg;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_e;

  localparam int RF_DW     = 32;
  localparam int RF_AW     = 5;
  localparam int RF_NR     = 4;
  localparam int RF_NW     = 2;
  localparam int RF_MAX_DW = 1024;

`ifdef RF_PARITY_EN
  localparam bit RF_PAR_EN = 1'b1;
`else
  localparam bit RF_PAR_EN = 1'b0;
`endif

  // Even parity: the stored bit makes the XOR of data plus parity equal zero.
  // Callers zero-extend to RF_MAX_DW, which leaves the XOR unchanged.
  function automatic logic rf_parity(input logic [RF_MAX_DW-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// rtl/rf_read_port.sv - one synchronous read port with write bypass, zero mux and parity check
// Ports: clk_i/rst_i clock and async active-high reset; busy_i masks output while clearing;
//        rd_addr_i read address; we_i/wr_addr_i/w_data_i qualified write ports;
//        addr_o registered address to the storage array; mem_data_i/mem_par_i stored entry;
//        r_data_o read data; perr_o parity error on storage-sourced reads.
// Optional feature macro: RF_PARITY_EN (via regfile_pkg::RF_PAR_EN).
module rf_read_port
  import regfile_pkg::*;
#(
  parameter int DW       = RF_DW,
  parameter int AW       = RF_AW,
  parameter int NW       = RF_NW,
  parameter int ZERO_REG = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             busy_i,
  input  logic [AW-1:0]    rd_addr_i,
  input  logic [NW-1:0]    we_i,
  input  logic [NW*AW-1:0] wr_addr_i,
  input  logic [NW*DW-1:0] w_data_i,
  output logic [AW-1:0]    addr_o,
  input  logic [DW-1:0]    mem_data_i,
  input  logic             mem_par_i,
  output logic [DW-1:0]    r_data_o,
  output logic             perr_o
);

  logic [AW-1:0] addr_q;
  logic          byp_hit_q, byp_hit_d;
  logic [DW-1:0] byp_data_q, byp_data_d;
  logic          wt_hit;
  logic [DW-1:0] wt_data;
  logic          is_zero;

  // Ascending loop so the highest-indexed matching write port wins.
  // we_i is already gated by BUSY and the zero-register drop in the top.
  always_comb begin
    byp_hit_d  = 1'b0;
    byp_data_d = '0;
    wt_hit     = 1'b0;
    wt_data    = '0;
    for (int j = 0; j < NW; j++) begin
      if (we_i[j] && (wr_addr_i[j*AW +: AW] == rd_addr_i)) begin
        byp_hit_d  = 1'b1;
        byp_data_d = w_data_i[j*DW +: DW];
      end
      if (we_i[j] && (wr_addr_i[j*AW +: AW] == addr_q)) begin
        wt_hit  = 1'b1;
        wt_data = w_data_i[j*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q     <= '0;
      byp_hit_q  <= 1'b0;
      byp_data_q <= '0;
    end else begin
      addr_q     <= rd_addr_i;
      byp_hit_q  <= byp_hit_d;
      byp_data_q <= byp_data_d;
    end
  end

  assign addr_o  = addr_q;
  assign is_zero = (ZERO_REG != 0) && (addr_q == '0);

  always_comb begin
    r_data_o = '0;
    perr_o   = 1'b0;
    if (!busy_i) begin
      if (is_zero) begin
        r_data_o = '0;
      end else if (wt_hit) begin
        r_data_o = wt_data;
      end else if (byp_hit_q) begin
        r_data_o = byp_data_q;
      end else begin
        r_data_o = mem_data_i;
        perr_o   = RF_PAR_EN && (mem_par_i != rf_parity(RF_MAX_DW'(mem_data_i)));
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - NR-read / NW-write register file with bypass and post-reset clear FSM
// Ports: CLK clock; RESET async active-high reset; RD_ADDR/R_DATA packed read ports;
//        WR_ADDR/W_DATA/WE packed write ports; BUSY high while clearing; PERR per-read-port
//        parity error.
// Optional feature macro: RF_PARITY_EN adds a stored even-parity bit per entry.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DW       = RF_DW,
  parameter int AW       = RF_AW,
  parameter int NR       = RF_NR,
  parameter int NW       = RF_NW,
  parameter int ZERO_REG = 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [NR*AW-1:0] RD_ADDR,
  output logic [NR*DW-1:0] R_DATA,
  input  logic [NW*AW-1:0] WR_ADDR,
  input  logic [NW*DW-1:0] W_DATA,
  input  logic [NW-1:0]    WE,
  output logic             BUSY,
  output logic [NR-1:0]    PERR
);

  localparam int DEPTH = 1 << AW;

  rf_state_e     state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          clr_we;
  logic [NW-1:0] we_eff;
  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] port_addr [NR];
  logic [NR-1:0] port_par;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= RF_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    case (state_q)
      RF_CLEAR: begin
        clr_we = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (&cnt_q) begin
          state_d = RF_READY;
          cnt_d   = '0;
        end
      end
      RF_READY: begin
        state_d = RF_READY;
      end
      default: begin
        state_d = RF_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  assign BUSY = (state_q == RF_CLEAR);

  // Writes are dropped while clearing and, with ZERO_REG, when aimed at entry 0;
  // the read ports see the same qualified enables so bypass never forwards a dropped write.
  always_comb begin
    we_eff = '0;
    for (int j = 0; j < NW; j++) begin
      we_eff[j] = WE[j] && (state_q == RF_READY) &&
                  !((ZERO_REG != 0) && (WR_ADDR[j*AW +: AW] == '0));
    end
  end

  // Later loop iterations override earlier ones: highest write port wins.
  always_ff @(posedge CLK) begin
    if (clr_we) begin
      mem_q[cnt_q] <= '0;
    end else begin
      for (int j = 0; j < NW; j++) begin
        if (we_eff[j]) begin
          mem_q[WR_ADDR[j*AW +: AW]] <= W_DATA[j*DW +: DW];
        end
      end
    end
  end

`ifdef RF_PARITY_EN
  logic par_q [DEPTH];

  always_ff @(posedge CLK) begin
    if (clr_we) begin
      par_q[cnt_q] <= 1'b0;
    end else begin
      for (int j = 0; j < NW; j++) begin
        if (we_eff[j]) begin
          par_q[WR_ADDR[j*AW +: AW]] <= rf_parity(RF_MAX_DW'(W_DATA[j*DW +: DW]));
        end
      end
    end
  end
`endif

  for (genvar k = 0; k < NR; k++) begin : g_rd
`ifdef RF_PARITY_EN
    assign port_par[k] = par_q[port_addr[k]];
`else
    assign port_par[k] = 1'b0;
`endif

    rf_read_port #(
      .DW       (DW),
      .AW       (AW),
      .NW       (NW),
      .ZERO_REG (ZERO_REG)
    ) u_port (
      .clk_i      (CLK),
      .rst_i      (RESET),
      .busy_i     (BUSY),
      .rd_addr_i  (RD_ADDR[k*AW +: AW]),
      .we_i       (we_eff),
      .wr_addr_i  (WR_ADDR),
      .w_data_i   (W_DATA),
      .addr_o     (port_addr[k]),
      .mem_data_i (mem_q[port_addr[k]]),
      .mem_par_i  (port_par[k]),
      .r_data_o   (R_DATA[k*DW +: DW]),
      .perr_o     (PERR[k])
    );
  end

endmodule
